dds_ctrl: RTL and testbench

Sequencer for the multi-tone dds datapath. It accepts configuration beats over a valid/ready interface and loads the thetas, deltas and ampls circulating FIFOs. It then runs the DDS by holding start, and frames the accumulator every N_TONES cycles. At each frame boundary it captures the summed output into a sample register with a valid strobe. It sits between the AXI-lite/stream config front end and the dds instance.

---
 rtl/dds_ctrl_pkg.sv | 27 ++
 rtl/dds_slot_pipe.sv | 48 ++++
 rtl/dds_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_dds_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_ctrl_pkg
// Description : Shared types and constants for the DDS sequencer: FSM state
//               encoding, table select codes and the idle FIFO address.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_ctrl_pkg;

   // Sequencer states, explicitly encoded.
   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2,
      RUN   = 2'd3
   } state_t;

   // Table select codes carried on s_cfg_sel; code 3 is illegal.
   localparam logic [1:0] THETAS = 2'd0;
   localparam logic [1:0] DELTAS = 2'd1;
   localparam logic [1:0] AMPLS  = 2'd2;

   // Address that selects no FIFO, so nothing shifts inside the dds.
   localparam logic [8:0] DDS_IDLE_ADDR = 9'h1FF;

endpackage : dds_ctrl_pkg
`default_nettype wire

// File: rtl/dds_slot_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dds_slot_pipe
// Description : DEPTH-deep delay line of {valid, slot index}. Tracks which
//               tone slot is entering the dds accumulator. i_flush clears
//               every in-flight valid bit synchronously. DEPTH must be >= 1.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_slot_pipe #(
   parameter int SLOT_W = 3,
   parameter int DEPTH  = 3
) (
   input  logic              clk,
   input  logic              a_rst_n,
   input  logic              i_flush,
   input  logic              i_valid,
   input  logic [SLOT_W-1:0] i_slot,
   output logic              o_valid,
   output logic [SLOT_W-1:0] o_slot
);

   logic [DEPTH-1:0]  r_valid;
   logic [SLOT_W-1:0] r_slot [DEPTH];

   // Shift the slot tags one stage per cycle; flush kills everything in flight.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= '0;
         end
      end else if (i_flush) begin
         r_valid <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_slot[0]  <= i_slot;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_slot[i]  <= r_slot[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_slot  = r_slot[DEPTH-1];

endmodule : dds_slot_pipe
`default_nettype wire

// File: rtl/dds_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_ctrl
// Description : Sequencer for the multi-tone dds datapath. Loads the theta,
//               delta and ampl circulating FIFOs from a valid/ready config
//               stream, runs the dds, frames the accumulator every N_TONES
//               cycles and captures each completed frame sum.
//               Optional build macro DDS_CTRL_FRAME_CNT_EN adds o_frame_cnt,
//               a 32-bit count of o_sample_valid strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_ctrl
   import dds_ctrl_pkg::*;
#(
   parameter int SIG_WIDTH = 16,
   parameter int N_TONES   = 8,
   parameter int PIPE_LAT  = 3
) (
   input  logic                 clk,
   input  logic                 a_rst_n,
   input  logic                 s_cfg_valid,
   output logic                 s_cfg_ready,
   input  logic [1:0]           s_cfg_sel,
   input  logic [SIG_WIDTH-1:0] s_cfg_data,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic                 i_clear,
   output logic                 o_dds_rst,
   output logic                 o_dds_start,
   output logic [8:0]           o_dds_addrs,
   output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
   output logic                 o_acc_clr,
   input  logic [SIG_WIDTH-1:0] i_dds_signal,
   output logic [SIG_WIDTH-1:0] o_sample,
   output logic                 o_sample_valid,
   output logic                 o_busy,
   output logic                 o_cfg_err
`ifdef DDS_CTRL_FRAME_CNT_EN
   ,
   output logic [31:0]          o_frame_cnt
`endif
);

   localparam int CNT_W  = $clog2(N_TONES + 1);
   localparam int SLOT_W = $clog2(N_TONES);

   state_t            r_state;
   state_t            w_next_state;
   logic [CNT_W-1:0]  r_cnt [3];
   logic [2:0]        w_full;
   logic              w_all_full;
   logic              w_sel_full;
   logic              w_accept;
   logic              w_write;
   logic              w_bad_beat;
   logic [SLOT_W-1:0] r_slot;
   logic [SLOT_W-1:0] w_slot_nxt;
   logic              w_issue_nxt;
   logic              w_pipe_valid;
   logic [SLOT_W-1:0] w_pipe_slot;
   logic              w_frame_start;
   logic              r_frame_seen;

   for (genvar g = 0; g < 3; g++) begin : g_full
      assign w_full[g] = (r_cnt[g] == CNT_W'(N_TONES));
   end
   assign w_all_full = &w_full;

   // Ready is the registered LOAD state and per-table full flags, muxed by the
   // live select so a full table back-pressures only its own beats.
   always_comb begin
      w_sel_full = 1'b0;
      case (s_cfg_sel)
         THETAS:  w_sel_full = w_full[0];
         DELTAS:  w_sel_full = w_full[1];
         AMPLS:   w_sel_full = w_full[2];
         default: w_sel_full = 1'b0;
      endcase
   end

   assign s_cfg_ready = (r_state == LOAD) && !w_sel_full;
   assign w_accept    = s_cfg_valid && s_cfg_ready;
   // A clear in the same cycle discards the beat.
   assign w_write     = w_accept && (s_cfg_sel != 2'd3) && (w_next_state == LOAD);
   assign w_bad_beat  = w_accept && (s_cfg_sel == 2'd3);

   // Next-state logic; clear beats stop, stop beats start.
   always_comb begin
      w_next_state = r_state;
      if (i_clear) begin
         w_next_state = CLEAR;
      end else begin
         case (r_state)
            CLEAR: w_next_state = LOAD;
            LOAD:  if (w_all_full) w_next_state = READY;
            READY: begin
               if (i_stop)       w_next_state = CLEAR;
               else if (i_start) w_next_state = RUN;
            end
            RUN:   if (i_stop) w_next_state = CLEAR;
            default: w_next_state = CLEAR;
         endcase
      end
   end

   // Slot index the dds FIFO head will present next cycle.
   assign w_issue_nxt = (w_next_state == RUN);
   always_comb begin
      w_slot_nxt = '0;
      if (w_issue_nxt && (r_state == RUN)) begin
         w_slot_nxt = (r_slot == SLOT_W'(N_TONES - 1)) ? '0 : r_slot + SLOT_W'(1);
      end
   end

   // The pipe is fed next-cycle issue info, so its last stage lines up with
   // the cycle before a product reaches the accumulator; that lets the frame
   // strobes below be plain registers.
   dds_slot_pipe #(
      .SLOT_W (SLOT_W),
      .DEPTH  (PIPE_LAT)
   ) u_slot_pipe (
      .clk     (clk),
      .a_rst_n (a_rst_n),
      .i_flush (!w_issue_nxt),
      .i_valid (w_issue_nxt),
      .i_slot  (w_slot_nxt),
      .o_valid (w_pipe_valid),
      .o_slot  (w_pipe_slot)
   );

   assign w_frame_start = w_issue_nxt && w_pipe_valid && (w_pipe_slot == '0);

   // State register plus the state-derived control outputs.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         r_state     <= CLEAR;
         o_dds_rst   <= 1'b1;
         o_dds_start <= 1'b0;
         o_busy      <= 1'b0;
         r_slot      <= '0;
      end else begin
         r_state     <= w_next_state;
         o_dds_rst   <= (w_next_state == CLEAR);
         o_dds_start <= w_issue_nxt;
         o_busy      <= w_issue_nxt;
         r_slot      <= w_slot_nxt;
      end
   end

   // Table writes: present each accepted beat to the dds and count it.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         o_dds_addrs     <= DDS_IDLE_ADDR;
         o_dds_fifo_data <= '0;
         o_cfg_err       <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         if (w_write) begin
            o_dds_addrs     <= {7'd0, s_cfg_sel};
            o_dds_fifo_data <= s_cfg_data;
         end else begin
            o_dds_addrs     <= DDS_IDLE_ADDR;
         end
         if (w_next_state == CLEAR) begin
            o_cfg_err <= 1'b0;
         end else if (w_bad_beat) begin
            o_cfg_err <= 1'b1;
         end
         for (int i = 0; i < 3; i++) begin
            if (w_next_state == CLEAR) begin
               r_cnt[i] <= '0;
            end else if (w_write && (s_cfg_sel == 2'(i))) begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Frame strobes and sample capture; the first frame of a run has no
   // complete predecessor, so it clears the accumulator without a sample.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         o_acc_clr      <= 1'b0;
         o_sample_valid <= 1'b0;
         o_sample       <= '0;
         r_frame_seen   <= 1'b0;
      end else begin
         o_acc_clr      <= w_frame_start;
         o_sample_valid <= w_frame_start && r_frame_seen;
         if (w_frame_start && r_frame_seen) begin
            o_sample <= i_dds_signal;
         end
         r_frame_seen   <= w_issue_nxt && (r_frame_seen || w_frame_start);
      end
   end

`ifdef DDS_CTRL_FRAME_CNT_EN
   // Count delivered samples; wraps naturally at 2^32.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         o_frame_cnt <= '0;
      end else if (w_next_state == CLEAR) begin
         o_frame_cnt <= '0;
      end else if (w_frame_start && r_frame_seen) begin
         o_frame_cnt <= o_frame_cnt + 32'd1;
      end
   end
`endif

endmodule : dds_ctrl
`default_nettype wire

// File: tb/tb_dds_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_ctrl
// Description : Directed self-checking bench for dds_ctrl (N_TONES=8,
//               PIPE_LAT=3). Connects o_frame_cnt when DDS_CTRL_FRAME_CNT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_ctrl;

   localparam int SW = 16;

   logic          clk;
   logic          a_rst_n;
   logic          s_cfg_valid;
   logic          s_cfg_ready;
   logic [1:0]    s_cfg_sel;
   logic [SW-1:0] s_cfg_data;
   logic          i_start;
   logic          i_stop;
   logic          i_clear;
   logic          o_dds_rst;
   logic          o_dds_start;
   logic [8:0]    o_dds_addrs;
   logic [SW-1:0] o_dds_fifo_data;
   logic          o_acc_clr;
   logic [SW-1:0] i_dds_signal;
   logic [SW-1:0] o_sample;
   logic          o_sample_valid;
   logic          o_busy;
   logic          o_cfg_err;
`ifdef DDS_CTRL_FRAME_CNT_EN
   logic [31:0]   o_frame_cnt;
`endif

   int pass_cnt = 0;
   int chk_cnt  = 0;

   dds_ctrl #(
      .SIG_WIDTH (SW),
      .N_TONES   (8),
      .PIPE_LAT  (3)
   ) u_dut (
      .clk             (clk),
      .a_rst_n         (a_rst_n),
      .s_cfg_valid     (s_cfg_valid),
      .s_cfg_ready     (s_cfg_ready),
      .s_cfg_sel       (s_cfg_sel),
      .s_cfg_data      (s_cfg_data),
      .i_start         (i_start),
      .i_stop          (i_stop),
      .i_clear         (i_clear),
      .o_dds_rst       (o_dds_rst),
      .o_dds_start     (o_dds_start),
      .o_dds_addrs     (o_dds_addrs),
      .o_dds_fifo_data (o_dds_fifo_data),
      .o_acc_clr       (o_acc_clr),
      .i_dds_signal    (i_dds_signal),
      .o_sample        (o_sample),
      .o_sample_valid  (o_sample_valid),
      .o_busy          (o_busy),
      .o_cfg_err       (o_cfg_err)
`ifdef DDS_CTRL_FRAME_CNT_EN
      ,
      .o_frame_cnt     (o_frame_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [SW-1:0] sig_at(input int c);
      return SW'(16'h4000 + c * 37);
   endfunction

   // Stimulus-only table load: 8 beats for each of the three tables.
   task automatic load_all();
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 8; i++) begin
            s_cfg_valid = 1'b1;
            s_cfg_sel   = 2'(s);
            s_cfg_data  = SW'(i + 1);
            @(posedge clk); #1;
         end
      end
      s_cfg_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      a_rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++; if (o_dds_rst !== 1'b1) $display("FAIL rst_dds_rst got %b exp 1", o_dds_rst); else pass_cnt++;
      chk_cnt++; if (o_dds_addrs !== 9'h1FF) $display("FAIL rst_addrs got %h exp 1ff", o_dds_addrs); else pass_cnt++;
      chk_cnt++; if ({o_dds_start, o_busy, o_acc_clr, o_sample_valid, o_cfg_err} !== 5'b0)
         $display("FAIL rst_flags got %b exp 00000", {o_dds_start, o_busy, o_acc_clr, o_sample_valid, o_cfg_err}); else pass_cnt++;
      chk_cnt++; if (o_sample !== 16'h0) $display("FAIL rst_sample got %h exp 0", o_sample); else pass_cnt++;
      a_rst_n = 1'b1;
      #1;
      chk_cnt++; if (s_cfg_ready !== 1'b0) $display("FAIL clear_ready got %b exp 0", s_cfg_ready); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (o_dds_rst !== 1'b0) $display("FAIL load_dds_rst got %b exp 0", o_dds_rst); else pass_cnt++;
      chk_cnt++; if (s_cfg_ready !== 1'b1) $display("FAIL load_ready got %b exp 1", s_cfg_ready); else pass_cnt++;
      chk_cnt++; if (o_dds_addrs !== 9'h1FF) $display("FAIL load_idle_addr got %h exp 1ff", o_dds_addrs); else pass_cnt++;
   endtask

   task automatic test_load();
      logic [SW-1:0] d;
      for (int s = 0; s < 3; s++) begin
         if (s == 1) begin
            // illegal select: accepted, flagged, no write
            s_cfg_valid = 1'b1; s_cfg_sel = 2'd3; s_cfg_data = 16'hDEAD;
            #1;
            chk_cnt++; if (s_cfg_ready !== 1'b1) $display("FAIL bad_sel_ready got %b exp 1", s_cfg_ready); else pass_cnt++;
            @(posedge clk); #1;
            s_cfg_valid = 1'b0;
            chk_cnt++; if (o_dds_addrs !== 9'h1FF) $display("FAIL bad_sel_addr got %h exp 1ff", o_dds_addrs); else pass_cnt++;
            chk_cnt++; if (o_cfg_err !== 1'b1) $display("FAIL bad_sel_err got %b exp 1", o_cfg_err); else pass_cnt++;
            // ninth theta is refused
            s_cfg_valid = 1'b1; s_cfg_sel = 2'd0; s_cfg_data = 16'hBEEF;
            #1;
            chk_cnt++; if (s_cfg_ready !== 1'b0) $display("FAIL theta9_ready got %b exp 0", s_cfg_ready); else pass_cnt++;
            @(posedge clk); #1;
            s_cfg_valid = 1'b0;
            chk_cnt++; if (o_dds_addrs !== 9'h1FF) $display("FAIL theta9_addr got %h exp 1ff", o_dds_addrs); else pass_cnt++;
            // start and stop are both ignored while loading
            i_start = 1'b1; i_stop = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0; i_stop = 1'b0;
            chk_cnt++; if (o_dds_start !== 1'b0) $display("FAIL load_start_ign got %b exp 0", o_dds_start); else pass_cnt++;
            chk_cnt++; if (o_cfg_err !== 1'b1) $display("FAIL load_stop_ign err got %b exp 1", o_cfg_err); else pass_cnt++;
         end
         for (int i = 0; i < 8; i++) begin
            d = SW'((s + 1) * 4096 + i * 17);
            s_cfg_valid = 1'b1; s_cfg_sel = 2'(s); s_cfg_data = d;
            #1;
            chk_cnt++; if (s_cfg_ready !== 1'b1) $display("FAIL beat_ready s%0d i%0d got %b exp 1", s, i, s_cfg_ready); else pass_cnt++;
            @(posedge clk); #1;
            chk_cnt++; if (o_dds_addrs !== 9'(s)) $display("FAIL beat_addr s%0d i%0d got %h exp %h", s, i, o_dds_addrs, 9'(s)); else pass_cnt++;
            chk_cnt++; if (o_dds_fifo_data !== d) $display("FAIL beat_data s%0d i%0d got %h exp %h", s, i, o_dds_fifo_data, d); else pass_cnt++;
         end
      end
      s_cfg_valid = 1'b0;
      @(posedge clk); #1;
      chk_cnt++; if (o_dds_addrs !== 9'h1FF) $display("FAIL post_load_addr got %h exp 1ff", o_dds_addrs); else pass_cnt++;
      s_cfg_valid = 1'b1; s_cfg_sel = 2'd3;
      #1;
      chk_cnt++; if (s_cfg_ready !== 1'b0) $display("FAIL ready_in_ready got %b exp 0", s_cfg_ready); else pass_cnt++;
      s_cfg_valid = 1'b0; s_cfg_sel = 2'd0;
   endtask

   task automatic test_run();
      logic exp_clr;
      logic exp_val;
      int   nval;
      nval = 0;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_dds_signal = sig_at(0);
      chk_cnt++; if (o_dds_start !== 1'b1) $display("FAIL start_rise got %b exp 1", o_dds_start); else pass_cnt++;
      chk_cnt++; if (o_busy !== 1'b1) $display("FAIL busy_rise got %b exp 1", o_busy); else pass_cnt++;
      chk_cnt++; if (o_acc_clr !== 1'b0) $display("FAIL clr_early got %b exp 0", o_acc_clr); else pass_cnt++;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         exp_clr = (c >= 3) && (((c - 3) % 8) == 0);
         exp_val = exp_clr && (c > 3);
         chk_cnt++; if (o_acc_clr !== exp_clr) $display("FAIL acc_clr c%0d got %b exp %b", c, o_acc_clr, exp_clr); else pass_cnt++;
         chk_cnt++; if (o_sample_valid !== exp_val) $display("FAIL sample_valid c%0d got %b exp %b", c, o_sample_valid, exp_val); else pass_cnt++;
         if (exp_val) begin
            nval++;
            chk_cnt++; if (o_sample !== sig_at(c - 1)) $display("FAIL sample c%0d got %h exp %h", c, o_sample, sig_at(c - 1)); else pass_cnt++;
`ifdef DDS_CTRL_FRAME_CNT_EN
            chk_cnt++; if (o_frame_cnt !== 32'(nval)) $display("FAIL frame_cnt c%0d got %0d exp %0d", c, o_frame_cnt, nval); else pass_cnt++;
`endif
         end
         i_dds_signal = sig_at(c);
      end
      chk_cnt++; if (o_dds_start !== 1'b1) $display("FAIL start_held got %b exp 1", o_dds_start); else pass_cnt++;
   endtask

   task automatic test_stop_start();
      i_stop = 1'b1; i_start = 1'b1;
      @(posedge clk); #1;
      i_stop = 1'b0; i_start = 1'b0;
      chk_cnt++; if (o_dds_start !== 1'b0) $display("FAIL stop_start_fall got %b exp 0", o_dds_start); else pass_cnt++;
      chk_cnt++; if (o_busy !== 1'b0) $display("FAIL stop_busy got %b exp 0", o_busy); else pass_cnt++;
      chk_cnt++; if (o_dds_rst !== 1'b1) $display("FAIL stop_clear got %b exp 1", o_dds_rst); else pass_cnt++;
      chk_cnt++; if (o_cfg_err !== 1'b0) $display("FAIL stop_err_clr got %b exp 0", o_cfg_err); else pass_cnt++;
      for (int c = 0; c < 12; c++) begin
         chk_cnt++; if ({o_acc_clr, o_sample_valid} !== 2'b00)
            $display("FAIL after_stop c%0d clr/valid got %b exp 00", c, {o_acc_clr, o_sample_valid}); else pass_cnt++;
         @(posedge clk); #1;
      end
      chk_cnt++; if (o_sample !== sig_at(34)) $display("FAIL sample_hold got %h exp %h", o_sample, sig_at(34)); else pass_cnt++;
      s_cfg_sel = 2'd0;
      #1;
      chk_cnt++; if (s_cfg_ready !== 1'b1) $display("FAIL reload_ready got %b exp 1", s_cfg_ready); else pass_cnt++;
`ifdef DDS_CTRL_FRAME_CNT_EN
      chk_cnt++; if (o_frame_cnt !== 32'd0) $display("FAIL frame_cnt_clr got %0d exp 0", o_frame_cnt); else pass_cnt++;
`endif
   endtask

   task automatic test_clear();
      s_cfg_valid = 1'b1; s_cfg_sel = 2'd3; s_cfg_data = 16'h0;
      @(posedge clk); #1;
      s_cfg_valid = 1'b0;
      chk_cnt++; if (o_cfg_err !== 1'b1) $display("FAIL pre_clear_err got %b exp 1", o_cfg_err); else pass_cnt++;
      i_clear = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0;
      chk_cnt++; if (o_dds_rst !== 1'b1) $display("FAIL clear_rst got %b exp 1", o_dds_rst); else pass_cnt++;
      chk_cnt++; if (o_cfg_err !== 1'b0) $display("FAIL clear_err got %b exp 0", o_cfg_err); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      load_all();
      i_dds_signal = 16'h1234;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk_cnt++; if (o_sample !== 16'h1234) $display("FAIL run2_sample got %h exp 1234", o_sample); else pass_cnt++;
`ifdef DDS_CTRL_FRAME_CNT_EN
      chk_cnt++; if (o_frame_cnt !== 32'd2) $display("FAIL run2_frame_cnt got %0d exp 2", o_frame_cnt); else pass_cnt++;
`endif
      #3;
      a_rst_n = 1'b0;
      #1;
      chk_cnt++; if ({o_dds_rst, o_dds_start, o_busy} !== 3'b100)
         $display("FAIL async_rst ctl got %b exp 100", {o_dds_rst, o_dds_start, o_busy}); else pass_cnt++;
      chk_cnt++; if (o_dds_addrs !== 9'h1FF) $display("FAIL async_rst addr got %h exp 1ff", o_dds_addrs); else pass_cnt++;
      chk_cnt++; if (o_sample !== 16'h0) $display("FAIL async_rst sample got %h exp 0", o_sample); else pass_cnt++;
`ifdef DDS_CTRL_FRAME_CNT_EN
      chk_cnt++; if (o_frame_cnt !== 32'd0) $display("FAIL async_rst frame_cnt got %0d exp 0", o_frame_cnt); else pass_cnt++;
`endif
      @(posedge clk); #1;
      a_rst_n = 1'b1;
      @(posedge clk); #1;
      chk_cnt++; if ({o_dds_rst, s_cfg_ready} !== 2'b01)
         $display("FAIL post_rst rst/ready got %b exp 01", {o_dds_rst, s_cfg_ready}); else pass_cnt++;
   endtask

   initial begin
      a_rst_n      = 1'b0;
      s_cfg_valid  = 1'b0;
      s_cfg_sel    = 2'd0;
      s_cfg_data   = '0;
      i_start      = 1'b0;
      i_stop       = 1'b0;
      i_clear      = 1'b0;
      i_dds_signal = '0;
      test_reset();
      test_load();
      test_run();
      test_stop_start();
      test_clear();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_dds_ctrl
`default_nettype wire
